// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32I pipeline: result/ALU encodings, datapath
// width default and the decoder control bundle carried between stages.
package rv_pipe_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  // Packed so a bubble can clear the whole bundle with a single assignment.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
  } ctrl_t;

  function automatic logic is_load(input logic reg_write, input logic [1:0] result_src);
    return reg_write && (result_src == RES_MEM);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and redirect detection for the ID/EX boundary.
// A redirect suppresses the stall because the dependent instruction is flushed.
module hazard_detect
  import rv_pipe_pkg::*;
(
  input  logic       valid_e,
  input  logic       reg_write_e,
  input  logic [1:0] result_src_e,
  input  logic       jump_e,
  input  logic       branch_e,
  input  logic [4:0] rd_e,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic       zero_e,
  output logic       lw_stall,
  output logic       pc_src_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d
);

  logic load_use;

  assign pc_src_e = valid_e & (jump_e | (branch_e & zero_e));

  // rs fields are compared regardless of instruction format; a spurious stall is harmless.
  assign load_use = valid_e & is_load(reg_write_e, result_src_e) & (rd_e != 5'd0)
                  & ((rd_e == rs1_d) | (rd_e == rs2_d));

  assign lw_stall = load_use & ~pc_src_e;
  assign stall_f  = lw_stall;
  assign stall_d  = lw_stall;
  assign flush_d  = pc_src_e;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion on load-use stalls and taken
// branches/jumps, plus free-running stall and flush counters.
module id_ex_stage
  import rv_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reg_write_d,
  input  logic            mem_write_d,
  input  logic            jump_d,
  input  logic            branch_d,
  input  logic            alu_src_d,
  input  logic [1:0]      result_src_d,
  input  logic [2:0]      alu_control_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] imm_ext_d,
  input  logic [XLEN-1:0] pc_plus4_d,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic [4:0]      rd_d,
  input  logic            zero_e,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic            jump_e,
  output logic            branch_e,
  output logic            alu_src_e,
  output logic [1:0]      result_src_e,
  output logic [2:0]      alu_control_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [XLEN-1:0] pc_plus4_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic            valid_e,
  output logic            pc_src_e,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d,
  output logic [31:0]     stall_count,
  output logic [31:0]     flush_count
);

  ctrl_t ctrl_d, ctrl_q;
  logic  lw_stall, bubble;

  assign ctrl_d = '{reg_write:   reg_write_d,
                    result_src:  result_src_d,
                    mem_write:   mem_write_d,
                    jump:        jump_d,
                    branch:      branch_d,
                    alu_control: alu_control_d,
                    alu_src:     alu_src_d};

  assign reg_write_e   = ctrl_q.reg_write;
  assign result_src_e  = ctrl_q.result_src;
  assign mem_write_e   = ctrl_q.mem_write;
  assign jump_e        = ctrl_q.jump;
  assign branch_e      = ctrl_q.branch;
  assign alu_control_e = ctrl_q.alu_control;
  assign alu_src_e     = ctrl_q.alu_src;

  hazard_detect u_hazard (
    .valid_e      (valid_e),
    .reg_write_e  (reg_write_e),
    .result_src_e (result_src_e),
    .jump_e       (jump_e),
    .branch_e     (branch_e),
    .rd_e         (rd_e),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .zero_e       (zero_e),
    .lw_stall     (lw_stall),
    .pc_src_e     (pc_src_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d)
  );

  assign bubble = lw_stall | pc_src_e;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // so the hazard logic above always sees the current EX contents.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ctrl_q     <= '0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      pc_e       <= '0;
      imm_ext_e  <= '0;
      pc_plus4_e <= '0;
      rs1_e      <= '0;
      rs2_e      <= '0;
      rd_e       <= '0;
      valid_e    <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      rd1_e      <= rd1_d;
      rd2_e      <= rd2_d;
      pc_e       <= pc_d;
      imm_ext_e  <= imm_ext_d;
      pc_plus4_e <= pc_plus4_d;
      rs1_e      <= rs1_d;
      rs2_e      <= rs2_d;
      rd_e       <= rd_d;
      valid_e    <= 1'b1;
    end
  end

  // Counters wrap modulo 2^32 by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (lw_stall) stall_count <= stall_count + 32'd1;
      if (pc_src_e) flush_count <= flush_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage: reset, load-use, branch/jump
// flush, stall suppression under redirect, mid-run reset and counter wrap.
module tb_id_ex_stage;
  import rv_pipe_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0]      result_src_d;
  logic [2:0]      alu_control_d;
  logic [XLEN-1:0] rd1_d, rd2_d, pc_d, imm_ext_d, pc_plus4_d;
  logic [4:0]      rs1_d, rs2_d, rd_d;
  logic            zero_e;
  logic            reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
  logic [1:0]      result_src_e;
  logic [2:0]      alu_control_e;
  logic [XLEN-1:0] rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e;
  logic [4:0]      rs1_e, rs2_e, rd_e;
  logic            valid_e, pc_src_e, stall_f, stall_d, flush_d;
  logic [31:0]     stall_count, flush_count;

  int total = 0;
  int bad   = 0;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .reg_write_d(reg_write_d), .mem_write_d(mem_write_d), .jump_d(jump_d),
    .branch_d(branch_d), .alu_src_d(alu_src_d), .result_src_d(result_src_d),
    .alu_control_d(alu_control_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d),
    .imm_ext_d(imm_ext_d), .pc_plus4_d(pc_plus4_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rd_d(rd_d), .zero_e(zero_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .jump_e(jump_e),
    .branch_e(branch_e), .alu_src_e(alu_src_e), .result_src_e(result_src_e),
    .alu_control_e(alu_control_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e),
    .imm_ext_e(imm_ext_e), .pc_plus4_e(pc_plus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .valid_e(valid_e), .pc_src_e(pc_src_e), .stall_f(stall_f),
    .stall_d(stall_d), .flush_d(flush_d),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // K_JLD is a deliberately malformed bundle (jump plus load result) used to
  // exercise redirect-over-stall priority.
  typedef enum int {K_ADDI, K_LW, K_ADD, K_BEQ, K_JAL, K_JLD} kind_t;

  typedef struct {
    logic        rst;
    kind_t       kind;
    logic [4:0]  rs1, rs2, rd;
    logic        zero;
    logic        chk_comb;
    logic        e_pcsrc, e_stall, e_valid;
    logic [31:0] e_scnt, e_fcnt;
  } vec_t;

  function automatic ctrl_t ctl_of(input kind_t k);
    ctrl_t c = '0;
    case (k)
      K_ADDI: begin c.reg_write = 1'b1; c.result_src = RES_ALU; c.alu_src = 1'b1; c.alu_control = ALU_ADD; end
      K_LW:   begin c.reg_write = 1'b1; c.result_src = RES_MEM; c.alu_src = 1'b1; c.alu_control = ALU_ADD; end
      K_ADD:  begin c.reg_write = 1'b1; c.result_src = RES_ALU; c.alu_control = ALU_ADD; end
      K_BEQ:  begin c.branch = 1'b1; c.alu_control = ALU_SUB; end
      K_JAL:  begin c.jump = 1'b1; c.reg_write = 1'b1; c.result_src = RES_PC4; end
      K_JLD:  begin c.jump = 1'b1; c.reg_write = 1'b1; c.result_src = RES_MEM; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic vec_t mk(input logic r, input kind_t k, input int s1, input int s2,
                              input int d, input logic z, input logic cc, input logic pcs,
                              input logic st, input logic v, input int sc, input int fc);
    vec_t t;
    t.rst = r; t.kind = k; t.rs1 = 5'(s1); t.rs2 = 5'(s2); t.rd = 5'(d); t.zero = z;
    t.chk_comb = cc; t.e_pcsrc = pcs; t.e_stall = st; t.e_valid = v;
    t.e_scnt = 32'(sc); t.e_fcnt = 32'(fc);
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input int idx);
    ctrl_t c = ctl_of(v.kind);
    rst           = v.rst;
    reg_write_d   = c.reg_write;
    result_src_d  = c.result_src;
    mem_write_d   = c.mem_write;
    jump_d        = c.jump;
    branch_d      = c.branch;
    alu_control_d = c.alu_control;
    alu_src_d     = c.alu_src;
    rd1_d         = 32'hA000_0000 + 32'(idx);
    rd2_d         = 32'hB000_0000 + 32'(idx);
    pc_d          = 32'h0000_1000 + 32'(idx * 4);
    imm_ext_d     = 32'hFFFF_F000 | 32'(idx);
    pc_plus4_d    = 32'h0000_1004 + 32'(idx * 4);
    rs1_d         = v.rs1;
    rs2_d         = v.rs2;
    rd_d          = v.rd;
    zero_e        = v.zero;
  endtask

  task automatic check_comb(input string tag, input logic pcs, input logic st);
    check({tag, " pc_src_e"}, 64'(pc_src_e), 64'(pcs));
    check({tag, " flush_d"},  64'(flush_d),  64'(pcs));
    check({tag, " stall_f"},  64'(stall_f),  64'(st));
    check({tag, " stall_d"},  64'(stall_d),  64'(st));
  endtask

  // Expected EX contents: exactly what was driven when captured, all zero otherwise.
  task automatic check_regs(input string tag, input vec_t v, input int idx);
    ctrl_t ce = v.e_valid ? ctl_of(v.kind) : '0;
    ctrl_t ca = '{reg_write: reg_write_e, result_src: result_src_e, mem_write: mem_write_e,
                  jump: jump_e, branch: branch_e, alu_control: alu_control_e, alu_src: alu_src_e};
    check({tag, " valid_e"}, 64'(valid_e), 64'(v.e_valid));
    check({tag, " ctrl_e"},  64'(ca), 64'(ce));
    check({tag, " rd1_e"},   64'(rd1_e), v.e_valid ? 64'(32'hA000_0000 + 32'(idx)) : 64'd0);
    check({tag, " rd2_e"},   64'(rd2_e), v.e_valid ? 64'(32'hB000_0000 + 32'(idx)) : 64'd0);
    check({tag, " pc_e"},    64'(pc_e),  v.e_valid ? 64'(32'h0000_1000 + 32'(idx * 4)) : 64'd0);
    check({tag, " imm_e"},   64'(imm_ext_e), v.e_valid ? 64'(32'hFFFF_F000 | 32'(idx)) : 64'd0);
    check({tag, " pc4_e"},   64'(pc_plus4_e), v.e_valid ? 64'(32'h0000_1004 + 32'(idx * 4)) : 64'd0);
    check({tag, " rs_rd_e"}, 64'({rs1_e, rs2_e, rd_e}), v.e_valid ? 64'({v.rs1, v.rs2, v.rd}) : 64'd0);
    check({tag, " stall_count"}, 64'(stall_count), 64'(v.e_scnt));
    check({tag, " flush_count"}, 64'(flush_count), 64'(v.e_fcnt));
  endtask

  task automatic step(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    drive(v, idx);
    #1;
    if (v.chk_comb) check_comb(tag, v.e_pcsrc, v.e_stall);
    @(posedge clk);
    #1;
    check_regs(tag, v, idx);
  endtask

  vec_t vecs[21];

  initial begin
    //                rst kind    rs1 rs2 rd  z  chk pcs st  v  scnt fcnt
    vecs[0]  = mk(1, K_ADDI,  2, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, K_ADDI,  2, 0,  1, 0, 1, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, K_ADDI,  2, 0,  1, 0, 1, 0, 0, 1, 0, 0);
    vecs[3]  = mk(0, K_LW,    1, 0,  5, 0, 1, 0, 0, 1, 0, 0);
    vecs[4]  = mk(0, K_ADD,   4, 5,  6, 0, 1, 0, 1, 0, 1, 0);
    vecs[5]  = mk(0, K_ADD,   4, 5,  6, 0, 1, 0, 0, 1, 1, 0);
    vecs[6]  = mk(0, K_LW,    3, 0,  0, 0, 1, 0, 0, 1, 1, 0);
    vecs[7]  = mk(0, K_ADD,   0, 0,  7, 0, 1, 0, 0, 1, 1, 0);
    vecs[8]  = mk(0, K_LW,    2, 0,  5, 0, 1, 0, 0, 1, 1, 0);
    vecs[9]  = mk(0, K_ADD,   6, 7,  8, 0, 1, 0, 0, 1, 1, 0);
    vecs[10] = mk(0, K_BEQ,   8, 9,  0, 1, 1, 0, 0, 1, 1, 0);
    vecs[11] = mk(0, K_ADD,   1, 2,  9, 1, 1, 1, 0, 0, 1, 1);
    vecs[12] = mk(0, K_BEQ,   1, 1,  0, 0, 1, 0, 0, 1, 1, 1);
    vecs[13] = mk(0, K_ADD,   3, 4, 10, 0, 1, 0, 0, 1, 1, 1);
    vecs[14] = mk(0, K_JAL,   0, 0,  5, 0, 1, 0, 0, 1, 1, 1);
    vecs[15] = mk(0, K_ADD,   5, 0, 11, 0, 1, 1, 0, 0, 1, 2);
    vecs[16] = mk(0, K_JLD,   0, 0,  5, 0, 1, 0, 0, 1, 1, 2);
    vecs[17] = mk(0, K_ADD,   5, 5, 12, 0, 1, 1, 0, 0, 1, 3);
    vecs[18] = mk(0, K_ADD,   0, 0, 12, 0, 1, 0, 0, 1, 1, 3);
    vecs[19] = mk(0, K_LW,    0, 0,  5, 0, 1, 0, 0, 1, 1, 3);
    vecs[20] = mk(1, K_ADD,   0, 5,  6, 0, 1, 0, 1, 0, 0, 0);

    for (int i = 0; i < 21; i++) step(vecs[i], i);

    // Counter wrap: preload stall_count, then provoke one load-use stall.
    step(mk(0, K_LW, 0, 0, 5, 0, 1, 0, 0, 1, 0, 0), 30);
    @(negedge clk);
    force dut.stall_count = 32'hFFFF_FFFF;
    #1;
    release dut.stall_count;
    #1;
    check("wrap preload", 64'(stall_count), 64'h0000_0000_FFFF_FFFF);
    drive(mk(0, K_ADD, 1, 5, 6, 0, 1, 0, 1, 0, 0, 0), 31);
    #1;
    check_comb("wrap", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_regs("wrap", mk(0, K_ADD, 1, 5, 6, 0, 1, 0, 1, 0, 0, 0), 31);
    step(mk(0, K_ADD, 1, 5, 6, 0, 1, 0, 0, 1, 0, 0), 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute boundary of the five-stage RV32I pipeline. Captures the decoder's control bundle plus operands into the EX-stage register. Detects load-use hazards and resolves branches and jumps taken in EX, producing the stall/flush controls for fetch and decode. Keeps free-running stall and flush performance counters.

## Interface
- XLEN, 32, datapath width of operands, PC and immediate.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d  in  1 each  decoder control bits.
- result_src_d  in  2  result mux select (00 ALU, 01 memory, 10 PC+4).
- alu_control_d  in  3  ALU operation (000 add, 001 sub).
- rd1_d, rd2_d, pc_d, imm_ext_d, pc_plus4_d  in  XLEN each  decode operands.
- rs1_d, rs2_d, rd_d  in  5 each  register indices.
- zero_e  in  1  ALU zero flag from EX this cycle.
- *_e outputs  out  same widths as *_d  registered EX copies of every *_d input above.
- valid_e  out  1  EX slot holds a real instruction.
- pc_src_e  out  1  redirect fetch to the branch/jump target.
- stall_f, stall_d  out  1 each  hold PC and the IF/ID register.
- flush_d  out  1  clear the IF/ID register.
- stall_count, flush_count  out  32 each  performance counters.

## Operation
- pc_src_e = valid_e & (jump_e | (branch_e & zero_e)). Combinational.
- lw_stall = valid_e & reg_write_e & (result_src_e == 01) & (rd_e != 0) & (rd_e == rs1_d | rd_e == rs2_d). Combinational.
  - rs fields are compared even for formats that do not use them. Conservative stalls are accepted.
- If pc_src_e = 1, lw_stall is forced to 0.
  - flush wins: the younger decode instruction is discarded anyway.
  - In legal streams the two cannot both be active, since a load is never a branch or jump.
- stall_f = stall_d = lw_stall.
- flush_d = pc_src_e.
- Bubble condition: bubble = lw_stall | pc_src_e.
- Per rising edge:
  - rst: all *_e registers ← 0, valid_e ← 0, both counters ← 0.
  - Otherwise, if bubble: all *_e registers ← 0 and valid_e ← 0. The zeroed control bundle is a NOP, so no RegWrite, MemWrite, Branch or Jump.
  - Otherwise: every *_e ← *_d and valid_e ← 1.
- Counters:
  - stall_count increments on each non-reset cycle with lw_stall = 1.
  - flush_count increments on each non-reset cycle with pc_src_e = 1.
  - Both are modulo 2^32 and wrap 0xFFFFFFFF → 0 silently.
- The block has no internal FSM beyond valid_e. Hazard state is the EX register contents themselves.

## Timing
- Latency: one cycle from decode inputs to *_e outputs.
- pc_src_e, lw_stall, stall_*, flush_d are same-cycle combinational from EX registers, rs1_d/rs2_d and zero_e. There is no registered delay.
- Load-use costs exactly one bubble.
  - Cycle N: the load is in EX and the dependent instruction is in D, so stall and bubble assert.
  - Cycle N+1: the load has moved on, the dependent instruction enters EX, and the stall deasserts.
- A taken branch or jump costs two slots: the D instruction is flushed and the EX bubble is inserted in the same cycle.
- Reset mid-operation: reset overrides bubble and capture. Outputs are 0 the cycle after rst is sampled high. pc_src_e and the stalls are 0 while valid_e = 0.
- Reset values: every *_e = 0, valid_e = 0, pc_src_e = 0, stall_f = stall_d = flush_d = 0, counters = 0.

## Structure
- Shared package rv_pipe_pkg holds:
  - ResultSrc encodings RES_ALU = 00, RES_MEM = 01, RES_PC4 = 10.
  - ALU encodings ALU_ADD = 000, ALU_SUB = 001.
  - XLEN default.
  - A packed struct for the control bundle (reg_write, result_src, mem_write, jump, branch, alu_control, alu_src), so bubble clears it as one field.
- One sub-module, hazard_detect: purely combinational lw_stall / pc_src_e / stall / flush logic. The pipeline register and counters stay in id_ex_stage.

## Test plan
- Reset: drive nonzero *_d with rst = 1 for 2 cycles. Expect all *_e = 0, valid_e = 0, counters = 0. After release, addi x1 inputs appear on *_e one cycle later with valid_e = 1.
- Load-use: lw x5 in EX (rd_e = 5, result_src_e = 01, reg_write_e = 1), add with rs2_d = 5 in D. Expect stall_f = stall_d = 1 that cycle, next-cycle valid_e = 0 and reg_write_e = 0, stall_count = 1. The following cycle add is captured.
- No false stall: lw x0 in EX with rs1_d = 0 gives stall_f = 0. lw x5 with rs1_d = 6, rs2_d = 7 gives stall_f = 0.
- Taken branch: beq in EX (branch_e = 1) with zero_e = 1 gives pc_src_e = 1, flush_d = 1, next valid_e = 0, flush_count = 1. With zero_e = 0, pc_src_e = 0 and D is captured normally.
- Jump with simultaneous hazard inputs: jal in EX with rd_e = 5 and rs1_d = 5 gives pc_src_e = 1, stall_f = 0, flush_count increments and stall_count unchanged.
- Counter wrap: preload stall_count = 0xFFFFFFFF via a force/backdoor, create one load-use stall, expect 0x00000000.
